// File: rtl/dbus_lsu.sv
// dbus_lsu: memory-stage load/store unit; one op -> one dbus request, handshake, lane extract/extend.
// Optional misalignment fault checking is enabled by defining DBUS_LSU_ALIGN_CHECK_EN.
module dbus_lsu #(
  parameter int MAX_WAIT = 0
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        op_valid,
  input  logic        op_store,
  input  logic [1:0]  op_size,
  input  logic        op_unsigned,
  input  logic [31:0] op_addr,
  input  logic [31:0] op_wdata,
  output logic        dreq_valid,
  output logic [31:0] dreq_addr,
  output logic [2:0]  dreq_size,
  output logic [3:0]  dreq_strobe,
  output logic [31:0] dreq_data,
  input  logic        dresp_addr_ok,
  input  logic        dresp_data_ok,
  input  logic [31:0] dresp_data,
  output logic        busy,
  output logic        done,
  output logic [31:0] rdata,
  output logic        err
);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] REQ  = 2'd1;
  localparam logic [1:0] WAIT = 2'd2;
  localparam logic [1:0] DONE = 2'd3;
  localparam logic [2:0] MSIZE1 = 3'd0;
  localparam logic [2:0] MSIZE2 = 3'd1;
  localparam logic [2:0] MSIZE4 = 3'd2;
  localparam logic [7:0] WAIT_LAST = 8'(MAX_WAIT - 1);
  logic [1:0]  state;
  logic [1:0]  off;
  logic [1:0]  off_n;
  logic        load_uns;
  logic        store;
  logic [7:0]  cnt;
  logic        is_b;
  logic        is_h;
  logic        mis;
  logic        timeout;
  logic [2:0]  size_n;
  logic [3:0]  strobe_n;
  logic [31:0] data_n;
  logic [31:0] shifted;
  logic [31:0] load_val;
  assign dreq_valid = state == REQ;
  assign busy = state != IDLE;
  assign done = state == DONE;
  assign timeout = (MAX_WAIT > 0) && (cnt == WAIT_LAST);
  // decode the incoming op into lane offset, bus size, byte strobe and replicated store data
  always_comb begin
    is_b = op_size == 2'd0;
    is_h = op_size == 2'd1;
    off_n = is_b ? op_addr[1:0] : is_h ? {op_addr[1], 1'b0} : 2'b00;
    size_n = is_b ? MSIZE1 : is_h ? MSIZE2 : MSIZE4;
    strobe_n = !op_store ? 4'b0000 : is_b ? 4'b0001 << off_n : is_h ? 4'b0011 << off_n : 4'b1111;
    data_n = is_b ? {4{op_wdata[7:0]}} : is_h ? {2{op_wdata[15:0]}} : op_wdata;
`ifdef DBUS_LSU_ALIGN_CHECK_EN
    mis = (is_h & op_addr[0]) | (!is_b & !is_h & |op_addr[1:0]);
`else
    mis = 1'b0;
`endif
  end
  // pull the addressed lane down to bit 0 and sign/zero-extend it
  always_comb begin
    shifted = dresp_data >> {off, 3'b000};
    load_val = dreq_size == MSIZE1 ? {{24{~load_uns & shifted[7]}}, shifted[7:0]}
             : dreq_size == MSIZE2 ? {{16{~load_uns & shifted[15]}}, shifted[15:0]}
             : shifted;
  end
  // op sequencer: latch in IDLE, hold request until addr_ok, wait for data_ok or watchdog, pulse done
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state <= IDLE;
      rdata <= '0;
      err <= 1'b0;
      cnt <= '0;
      off <= '0;
      load_uns <= 1'b0;
      store <= 1'b0;
      dreq_addr <= '0;
      dreq_size <= MSIZE1;
      dreq_strobe <= '0;
      dreq_data <= '0;
    end else begin
      case (state)
        IDLE: if (op_valid) begin
          dreq_addr <= {op_addr[31:2], 2'b00};
          dreq_size <= size_n;
          dreq_strobe <= strobe_n;
          dreq_data <= data_n;
          off <= off_n;
          load_uns <= op_unsigned;
          store <= op_store;
          state <= mis ? DONE : REQ;
          if (mis) begin
            rdata <= '0;
            err <= 1'b1;
          end
        end
        REQ: if (dresp_addr_ok) begin
          state <= dresp_data_ok ? DONE : WAIT;
          cnt <= '0;
          if (dresp_data_ok) begin
            rdata <= store ? '0 : load_val;
            err <= 1'b0;
          end
        end
        WAIT: begin
          cnt <= cnt + 8'd1;
          if (dresp_data_ok || timeout) begin
            state <= DONE;
            rdata <= (store || !dresp_data_ok) ? '0 : load_val;
            err <= !dresp_data_ok;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_dbus_lsu.sv
// tb_dbus_lsu: directed scoreboard bench for dbus_lsu with a scripted bridge model (MAX_WAIT=4)
module tb_dbus_lsu;
  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        op_valid = 1'b0;
  logic        op_store = 1'b0;
  logic [1:0]  op_size = 2'd0;
  logic        op_unsigned = 1'b0;
  logic [31:0] op_addr = '0;
  logic [31:0] op_wdata = '0;
  logic        dreq_valid;
  logic [31:0] dreq_addr;
  logic [2:0]  dreq_size;
  logic [3:0]  dreq_strobe;
  logic [31:0] dreq_data;
  logic        dresp_addr_ok = 1'b0;
  logic        dresp_data_ok = 1'b0;
  logic [31:0] dresp_data = '0;
  logic        busy;
  logic        done;
  logic [31:0] rdata;
  logic        err;
  int tests = 0;
  int fails = 0;
  typedef struct {
    logic [31:0] addr;
    logic [2:0]  size;
    logic [3:0]  strobe;
    logic [31:0] data;
  } req_t;
  typedef struct {
    logic [31:0] rdata;
    logic        err;
  } rsp_t;
  req_t rq[$];
  rsp_t sq[$];
  rsp_t mon_e;
  int aok_delay = 0;
  int dok_delay = 1;
  bit dok_never = 1'b0;
  logic [31:0] bdata = '0;
  int vcnt = 0;
  int wcnt = 0;
  bit pend = 1'b0;

  always #5 clk = ~clk;

  dbus_lsu #(.MAX_WAIT(4)) dut (
    .clk(clk), .resetn(resetn), .op_valid(op_valid), .op_store(op_store), .op_size(op_size),
    .op_unsigned(op_unsigned), .op_addr(op_addr), .op_wdata(op_wdata),
    .dreq_valid(dreq_valid), .dreq_addr(dreq_addr), .dreq_size(dreq_size),
    .dreq_strobe(dreq_strobe), .dreq_data(dreq_data),
    .dresp_addr_ok(dresp_addr_ok), .dresp_data_ok(dresp_data_ok), .dresp_data(dresp_data),
    .busy(busy), .done(done), .rdata(rdata), .err(err)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // bridge model: addr_ok after aok_delay valid cycles, data_ok dok_delay cycles after addr_ok
  always @(posedge clk) begin
    #1;
    dresp_addr_ok = 1'b0;
    dresp_data_ok = 1'b0;
    if (!resetn) begin
      pend = 1'b0;
      vcnt = 0;
    end else if (pend) begin
      if (wcnt <= 1) begin
        dresp_data_ok = 1'b1;
        pend = 1'b0;
      end else wcnt--;
    end else if (dreq_valid) begin
      if (vcnt >= aok_delay) begin
        dresp_addr_ok = 1'b1;
        vcnt = 0;
        if (!dok_never) begin
          if (dok_delay == 0) dresp_data_ok = 1'b1;
          else begin
            pend = 1'b1;
            wcnt = dok_delay;
          end
        end
      end else vcnt++;
    end
    dresp_data = dresp_data_ok ? bdata : 32'h5A5A5A5A;
  end

  // monitor: every valid request cycle and every done pulse is checked against the queues
  always @(negedge clk) begin
    if (resetn) begin
      if (dreq_valid) begin
        if (rq.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL req_unexpected: dreq_valid=1 addr %h, no request expected", dreq_addr);
        end else begin
          check("req_addr", dreq_addr, rq[0].addr);
          check("req_size", 32'(dreq_size), 32'(rq[0].size));
          check("req_strobe", 32'(dreq_strobe), 32'(rq[0].strobe));
          check("req_data", dreq_data, rq[0].data);
          if (dresp_addr_ok) void'(rq.pop_front());
        end
      end
      if (done) begin
        if (sq.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL done_unexpected: done=1 rdata %h, no completion expected", rdata);
        end else begin
          mon_e = sq.pop_front();
          check("rdata", rdata, mon_e.rdata);
          check("err", 32'(err), 32'(mon_e.err));
          check("busy_in_done", 32'(busy), 32'd1);
        end
      end
    end
  end

  task automatic run(input string nm, input bit st, input logic [1:0] sz, input bit uns,
                     input logic [31:0] a, input logic [31:0] wd, input logic [31:0] bd,
                     input int ad, input int dd, input bit exp_req,
                     input logic [31:0] e_addr, input logic [2:0] e_size, input logic [3:0] e_strobe,
                     input logic [31:0] e_data, input logic [31:0] e_rdata, input bit e_err,
                     input int e_lat);
    int n = 0;
    aok_delay = ad;
    dok_delay = dd;
    dok_never = 1'b0;
    bdata = bd;
    op_store = st;
    op_size = sz;
    op_unsigned = uns;
    op_addr = a;
    op_wdata = wd;
    op_valid = 1'b1;
    if (exp_req) rq.push_back('{e_addr, e_size, e_strobe, e_data});
    sq.push_back('{e_rdata, e_err});
    @(posedge clk); #2;
    while (!done && n < 40) begin
      @(posedge clk); #2;
      n++;
    end
    check({nm, "_latency"}, 32'(n), 32'(e_lat));
    op_valid = 1'b0;
    @(posedge clk); #2;
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #2;
    check("rst_valid", 32'(dreq_valid), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_rdata", rdata, 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    resetn = 1'b1;
    @(posedge clk); #2;
    run("lw",       0, 2'd2, 0, 32'h100, 32'h0,        32'hDEADBEEF, 0, 1, 1, 32'h100, 3'd2, 4'b0000, 32'h0,        32'hDEADBEEF, 0, 2);
    run("lb",       0, 2'd0, 0, 32'h103, 32'h0,        32'h80AABBCC, 0, 1, 1, 32'h100, 3'd0, 4'b0000, 32'h0,        32'hFFFFFF80, 0, 2);
    run("lbu",      0, 2'd0, 1, 32'h103, 32'h0,        32'h80AABBCC, 0, 1, 1, 32'h100, 3'd0, 4'b0000, 32'h0,        32'h00000080, 0, 2);
    run("sh",       1, 2'd1, 0, 32'h102, 32'h1234ABCD, 32'h0,        0, 1, 1, 32'h100, 3'd1, 4'b1100, 32'hABCDABCD, 32'h0,        0, 2);
    run("lh",       0, 2'd1, 0, 32'h106, 32'h0,        32'h80017FFF, 0, 1, 1, 32'h104, 3'd1, 4'b0000, 32'h0,        32'hFFFF8001, 0, 2);
    run("lhu",      0, 2'd1, 1, 32'h106, 32'h0,        32'h80017FFF, 0, 1, 1, 32'h104, 3'd1, 4'b0000, 32'h0,        32'h00008001, 0, 2);
    run("lb_same",  0, 2'd0, 0, 32'h101, 32'h0,        32'h00007F00, 0, 0, 1, 32'h100, 3'd0, 4'b0000, 32'h0,        32'h0000007F, 0, 1);
    run("sb",       1, 2'd0, 0, 32'h003, 32'h000000A5, 32'h0,        0, 1, 1, 32'h000, 3'd0, 4'b1000, 32'hA5A5A5A5, 32'h0,        0, 2);
    run("sw_stall", 1, 2'd2, 0, 32'h204, 32'hCAFEF00D, 32'h0,        3, 1, 1, 32'h204, 3'd2, 4'b1111, 32'hCAFEF00D, 32'h0,        0, 5);
    run("lw_sz3",   0, 2'd3, 0, 32'h008, 32'h0,        32'h01020304, 0, 2, 1, 32'h008, 3'd2, 4'b0000, 32'h0,        32'h01020304, 0, 3);
    run("lw_dd4",   0, 2'd2, 0, 32'h00C, 32'h0,        32'h55AA55AA, 0, 4, 1, 32'h00C, 3'd2, 4'b0000, 32'h0,        32'h55AA55AA, 0, 5);
    run("lh_tmo",   0, 2'd1, 0, 32'h010, 32'h0,        32'hFFFF0000, 0, 5, 1, 32'h010, 3'd1, 4'b0000, 32'h0,        32'h0,        1, 5);
`ifdef DBUS_LSU_ALIGN_CHECK_EN
    run("lw_mis",   0, 2'd2, 0, 32'h101, 32'h0,        32'h11223344, 0, 1, 0, 32'h0,   3'd0, 4'b0000, 32'h0,        32'h0,        1, 0);
    run("lh_mis",   0, 2'd1, 0, 32'h003, 32'h0,        32'hBEEF1234, 0, 1, 0, 32'h0,   3'd0, 4'b0000, 32'h0,        32'h0,        1, 0);
`else
    run("lw_mis",   0, 2'd2, 0, 32'h101, 32'h0,        32'h11223344, 0, 1, 1, 32'h100, 3'd2, 4'b0000, 32'h0,        32'h11223344, 0, 2);
    run("lh_mis",   0, 2'd1, 0, 32'h003, 32'h0,        32'hBEEF1234, 0, 1, 1, 32'h000, 3'd1, 4'b0000, 32'h0,        32'hFFFFBEEF, 0, 2);
`endif
    dok_never = 1'b1;
    aok_delay = 0;
    op_store = 1'b0;
    op_size = 2'd2;
    op_addr = 32'h40;
    op_valid = 1'b1;
    rq.push_back('{32'h40, 3'd2, 4'b0000, 32'h0});
    repeat (3) begin
      @(posedge clk); #2;
    end
    check("wait_busy", 32'(busy), 32'd1);
    resetn = 1'b0;
    op_valid = 1'b0;
    @(posedge clk); #2;
    check("rst_mid_valid", 32'(dreq_valid), 32'd0);
    check("rst_mid_done", 32'(done), 32'd0);
    check("rst_mid_busy", 32'(busy), 32'd0);
    resetn = 1'b1;
    dok_never = 1'b0;
    repeat (3) begin
      @(posedge clk); #2;
    end
    check("post_rst_busy", 32'(busy), 32'd0);
    check("rq_empty", 32'(rq.size()), 32'd0);
    check("sq_empty", 32'(sq.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
